// File: rtl/tdm_pkg.sv
// Shared TDM definitions: framing state encoding, slot-counter width helper and
// default channel geometry common to the demux and its matching interleaver.
package tdm_pkg;

   localparam int TDM_N_CH_DEF = 4;
   localparam int TDM_W_DEF    = 8;

   typedef logic [0:0] tdm_state_t;
   localparam tdm_state_t ST_HUNT   = 1'b0;
   localparam tdm_state_t ST_LOCKED = 1'b1;

   // Slot counter width; never narrower than one bit.
   function automatic int tdm_slot_w(input int n_ch);
      return (n_ch <= 2) ? 1 : $clog2(n_ch);
   endfunction

endpackage

// File: rtl/tdm_slot_ctr.sv
// Slot position counter: load-to-1 on frame start, advance on enable, wrap to 0 after N_CH-1.
// o_wrap is combinational from the current count (slot is the last of the frame).
module tdm_slot_ctr
   import tdm_pkg::*;
#(
   parameter int N_CH = TDM_N_CH_DEF,
   parameter int SW   = tdm_slot_w(N_CH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_en,
   input  logic          i_load1,
   output logic [SW-1:0] o_slot,
   output logic          o_wrap
);

   localparam logic [SW-1:0] LAST_SLOT = SW'(N_CH - 1);

   logic [SW-1:0] r_slot;

   assign o_slot = r_slot;
   assign o_wrap = (r_slot == LAST_SLOT);

   // Load has priority: a frame start always restarts the count, even mid-frame.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_slot <= '0;
      end else if (i_load1) begin
         r_slot <= SW'(1);
      end else if (i_en) begin
         r_slot <= o_wrap ? '0 : r_slot + SW'(1);
      end
   end

endmodule

// File: rtl/tdm_demux.sv
// TDM demux: routes slot k of each SOF-marked frame to registered channel k, 1-cycle latency, no backpressure.
// TDM_DEMUX_FRAME_LATCH_EN: buffer slots in a shadow bank and publish all channels together at frame end.
module tdm_demux
   import tdm_pkg::*;
#(
   parameter int N_CH = TDM_N_CH_DEF,
   parameter int W    = TDM_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic              in_sof,
   input  logic [W-1:0]      in_data,
   output logic [N_CH*W-1:0] out_data,
   output logic [N_CH-1:0]   out_valid,
   output logic              frame_done,
   output logic              sync_err,
   output logic              locked
);

   localparam int SW = tdm_slot_w(N_CH);

   if (N_CH < 2) begin : g_bad_n_ch
      $error("tdm_demux: N_CH must be at least 2");
   end

   tdm_state_t          r_state;
   logic [N_CH*W-1:0]   r_out_data;
   logic [N_CH-1:0]     r_out_valid;
   logic                r_frame_done;
   logic                r_sync_err;

   logic [SW-1:0]       w_slot;
   logic                w_wrap;
   logic                w_hunt;
   logic                w_slot0;
   logic                w_sof;
   logic                w_early;
   logic                w_mid;
   logic                w_miss;
   logic                w_last;
   logic                w_wr_en;
   logic [SW-1:0]       w_wr_idx;
   logic [N_CH-1:0]     w_wr_sel;

   assign w_hunt  = (r_state == ST_HUNT);
   assign w_slot0 = (w_slot == '0);

   // An SOF beat is always taken as slot 0, whether it starts a frame or aborts one.
   assign w_sof   = in_valid & in_sof;
   assign w_early = w_sof & ~w_hunt & ~w_slot0;
   assign w_mid   = in_valid & ~in_sof & ~w_hunt & ~w_slot0;
   assign w_miss  = in_valid & ~in_sof & ~w_hunt & w_slot0;
   assign w_last  = w_mid & w_wrap;

   assign w_wr_en  = w_sof | w_mid;
   assign w_wr_idx = w_sof ? '0 : w_slot;

   always_comb begin
      w_wr_sel = '0;
      for (int k = 0; k < N_CH; k++) begin
         w_wr_sel[k] = w_wr_en && (w_wr_idx == SW'(k));
      end
   end

   tdm_slot_ctr #(
      .N_CH (N_CH),
      .SW   (SW)
   ) u_slot_ctr (
      .clk     (clk),
      .rst     (rst),
      .i_en    (w_mid),
      .i_load1 (w_sof),
      .o_slot  (w_slot),
      .o_wrap  (w_wrap)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_HUNT;
      end else if (w_sof) begin
         r_state <= ST_LOCKED;
      end else if (w_miss) begin
         r_state <= ST_HUNT;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_frame_done <= 1'b0;
         r_sync_err   <= 1'b0;
      end else begin
         r_frame_done <= w_last;
         r_sync_err   <= w_early | w_miss;
      end
   end

`ifdef TDM_DEMUX_FRAME_LATCH_EN
   logic [N_CH*W-1:0] r_shadow;
   logic [N_CH*W-1:0] w_merge;

   // The final slot bypasses the shadow so the completed frame publishes on its own edge.
   always_comb begin
      w_merge = r_shadow;
      for (int k = 0; k < N_CH; k++) begin
         if (w_wr_sel[k]) begin
            w_merge[k*W +: W] = in_data;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_shadow    <= '0;
         r_out_data  <= '0;
         r_out_valid <= '0;
      end else begin
         r_out_valid <= '0;
         if (w_early || w_miss) begin
            r_shadow <= '0;
         end
         for (int k = 0; k < N_CH; k++) begin
            if (w_wr_sel[k]) begin
               r_shadow[k*W +: W] <= in_data;
            end
         end
         if (w_last) begin
            r_out_data  <= w_merge;
            r_out_valid <= '1;
         end
      end
   end
`else
   always_ff @(posedge clk) begin
      if (rst) begin
         r_out_data  <= '0;
         r_out_valid <= '0;
      end else begin
         r_out_valid <= w_wr_sel;
         for (int k = 0; k < N_CH; k++) begin
            if (w_wr_sel[k]) begin
               r_out_data[k*W +: W] <= in_data;
            end
         end
      end
   end
`endif

   assign out_data   = r_out_data;
   assign out_valid  = r_out_valid;
   assign frame_done = r_frame_done;
   assign sync_err   = r_sync_err;
   assign locked     = (r_state == ST_LOCKED);

endmodule

// File: tb/tb_tdm_demux.sv
// Directed bench for tdm_demux (N_CH=4, W=8); expectations cover both the per-slot
// and the frame-latch builds, selected by the same macro as the design.
module tb_tdm_demux;

`ifdef TDM_DEMUX_FRAME_LATCH_EN
   localparam bit LATCH = 1'b1;
`else
   localparam bit LATCH = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_sof = 1'b0;
   logic [7:0]  in_data = '0;
   logic [31:0] out_data;
   logic [3:0]  out_valid;
   logic        frame_done;
   logic        sync_err;
   logic        locked;

   int n_chk = 0;
   int n_err = 0;

   tdm_demux #(
      .N_CH (4),
      .W    (8)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_sof     (in_sof),
      .in_data    (in_data),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .frame_done (frame_done),
      .sync_err   (sync_err),
      .locked     (locked)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] dsel(input logic [31:0] per_slot, input logic [31:0] latch);
      return LATCH ? latch : per_slot;
   endfunction

   function automatic logic [3:0] vsel(input logic [3:0] per_slot, input logic [3:0] latch);
      return LATCH ? latch : per_slot;
   endfunction

   // Drive one cycle of input, then sample all outputs 1 time unit after the edge.
   task automatic beat(input string tag, input logic v, input logic s, input logic [7:0] d,
                       input logic [31:0] e_dat, input logic [3:0] e_vld,
                       input logic e_fd, input logic e_err, input logic e_lk);
      in_valid = v;
      in_sof   = s;
      in_data  = d;
      @(posedge clk);
      #1;
      check({tag, ".data"},   out_data,   e_dat);
      check({tag, ".valid"},  {28'd0, out_valid}, {28'd0, e_vld});
      check({tag, ".fdone"},  {31'd0, frame_done}, {31'd0, e_fd});
      check({tag, ".serr"},   {31'd0, sync_err},   {31'd0, e_err});
      check({tag, ".locked"}, {31'd0, locked},     {31'd0, e_lk});
   endtask

   initial begin
      rst = 1'b1;
      @(posedge clk);
      beat("rst", 0, 0, 8'h00, 32'h0, 4'b0000, 0, 0, 0);
      rst = 1'b0;

      // Basic frame on consecutive cycles.
      beat("f1s0", 1, 1, 8'h11, dsel(32'h00000011, 32'h0), vsel(4'b0001, 4'b0000), 0, 0, 1);
      beat("f1s1", 1, 0, 8'h22, dsel(32'h00002211, 32'h0), vsel(4'b0010, 4'b0000), 0, 0, 1);
      beat("f1s2", 1, 0, 8'h33, dsel(32'h00332211, 32'h0), vsel(4'b0100, 4'b0000), 0, 0, 1);
      beat("f1s3", 1, 0, 8'h44, 32'h44332211, vsel(4'b1000, 4'b1111), 1, 0, 1);

      // Early SOF aborts the partial frame, then the restarted frame completes.
      beat("e_s0", 1, 1, 8'h10, dsel(32'h44332210, 32'h44332211), vsel(4'b0001, 4'b0000), 0, 0, 1);
      beat("e_s1", 1, 0, 8'h20, dsel(32'h44332010, 32'h44332211), vsel(4'b0010, 4'b0000), 0, 0, 1);
      beat("e_sof", 1, 1, 8'h30, dsel(32'h44332030, 32'h44332211), vsel(4'b0001, 4'b0000), 0, 1, 1);
      beat("e_s1b", 1, 0, 8'h40, dsel(32'h44334030, 32'h44332211), vsel(4'b0010, 4'b0000), 0, 0, 1);
      beat("e_s2b", 1, 0, 8'h50, dsel(32'h44504030, 32'h44332211), vsel(4'b0100, 4'b0000), 0, 0, 1);
      beat("e_s3b", 1, 0, 8'h60, 32'h60504030, vsel(4'b1000, 4'b1111), 1, 0, 1);

      // Missing SOF at slot 0 drops lock and leaves outputs alone.
      beat("miss", 1, 0, 8'h77, 32'h60504030, 4'b0000, 0, 1, 0);

      // Hunting: non-SOF beats are discarded until an SOF arrives.
      beat("h_aa", 1, 0, 8'hAA, 32'h60504030, 4'b0000, 0, 0, 0);
      beat("h_bb", 1, 0, 8'hBB, 32'h60504030, 4'b0000, 0, 0, 0);
      beat("h_sof", 1, 1, 8'h01, dsel(32'h60504001, 32'h60504030), vsel(4'b0001, 4'b0000), 0, 0, 1);
      beat("h_s1", 1, 0, 8'h02, dsel(32'h60500201, 32'h60504030), vsel(4'b0010, 4'b0000), 0, 0, 1);
      beat("h_s2", 1, 0, 8'h03, dsel(32'h60030201, 32'h60504030), vsel(4'b0100, 4'b0000), 0, 0, 1);
      beat("h_s3", 1, 0, 8'h04, 32'h04030201, vsel(4'b1000, 4'b1111), 1, 0, 1);

      // Gapped frame interrupted by reset between slot 1 and slot 2.
      beat("r_s0", 1, 1, 8'h05, dsel(32'h04030205, 32'h04030201), vsel(4'b0001, 4'b0000), 0, 0, 1);
      beat("r_gap0", 0, 0, 8'hEE, dsel(32'h04030205, 32'h04030201), 4'b0000, 0, 0, 1);
      beat("r_s1", 1, 0, 8'h06, dsel(32'h04030605, 32'h04030201), vsel(4'b0010, 4'b0000), 0, 0, 1);
      beat("r_gap1", 0, 0, 8'hEE, dsel(32'h04030605, 32'h04030201), 4'b0000, 0, 0, 1);
      rst = 1'b1;
      beat("r_rst", 1, 1, 8'hFF, 32'h0, 4'b0000, 0, 0, 0);
      rst = 1'b0;

      // Clean gapped frame after reset.
      beat("p_s0", 1, 1, 8'hA1, dsel(32'h000000A1, 32'h0), vsel(4'b0001, 4'b0000), 0, 0, 1);
      beat("p_gap0", 0, 1, 8'h00, dsel(32'h000000A1, 32'h0), 4'b0000, 0, 0, 1);
      beat("p_s1", 1, 0, 8'hA2, dsel(32'h0000A2A1, 32'h0), vsel(4'b0010, 4'b0000), 0, 0, 1);
      beat("p_s2", 1, 0, 8'hA3, dsel(32'h00A3A2A1, 32'h0), vsel(4'b0100, 4'b0000), 0, 0, 1);
      beat("p_gap1", 0, 0, 8'h00, dsel(32'h00A3A2A1, 32'h0), 4'b0000, 0, 0, 1);
      beat("p_s3", 1, 0, 8'hA4, 32'hA4A3A2A1, vsel(4'b1000, 4'b1111), 1, 0, 1);
      beat("p_idle", 0, 0, 8'h00, 32'hA4A3A2A1, 4'b0000, 0, 0, 1);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
